// File: rtl/signed_mac_acc.sv
// Signed multiply-accumulate over framed input beats: two-stage pipeline (product, accumulate)
// with optional saturation, a sticky overflow flag and a saturating beat counter.
module signed_mac_acc #(
    parameter int DW     = 22,
    parameter int ACC_W  = 48,
    parameter int CNT_W  = 16,
    parameter int SAT_EN = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [DW-1:0]    in_a,
    input  logic signed [DW-1:0]    in_b,
    input  logic                    in_last,
    input  logic                    acc_clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic                    out_ovf,
    output logic [CNT_W-1:0]        out_cnt,
    output logic                    busy
);

    localparam int PW = 2 * DW;

    generate
        if (ACC_W < 2 * DW) begin : g_bad_acc_w
            $error("signed_mac_acc: ACC_W must be at least 2*DW");
        end
    endgenerate

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACC   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [1:0]              state_q, state_d;
    logic                    rdy_en_q;
    logic signed [PW-1:0]    prod_q, prod_d;
    logic                    pv_q, pv_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    ovf_q, ovf_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    in_fire;
    logic                    out_fire;
    logic signed [ACC_W:0]   sum_wide;
    logic                    ovf_now;
    logic signed [ACC_W-1:0] acc_next;

    // in_ready stays low until the first edge after reset release, and drops with acc_clr.
    assign in_ready  = rdy_en_q && ((state_q == S_IDLE) || (state_q == S_ACC)) && !acc_clr;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign out_fire  = out_valid && out_ready;
    assign busy      = (state_q != S_IDLE);

    assign out_sum = out_valid ? acc_q : '0;
    assign out_ovf = out_valid ? ovf_q : 1'b0;
    assign out_cnt = out_valid ? cnt_q : '0;

    assign sum_wide = {acc_q[ACC_W-1], acc_q}
                    + {{(ACC_W + 1 - PW){prod_q[PW-1]}}, prod_q};
    assign ovf_now  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

    always_comb begin
        // NOTE: every combinationally assigned variable gets a default first so no latch is inferred.
        acc_next = sum_wide[ACC_W-1:0];
        if (ovf_now && (SAT_EN != 0)) begin
            acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    always_comb begin
        state_d = state_q;
        prod_d  = prod_q;
        pv_d    = in_fire;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        if (in_fire) begin
            prod_d = PW'(in_a) * PW'(in_b);
        end

        if (pv_q) begin
            acc_d = acc_next;
            ovf_d = ovf_q | ovf_now;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE:  if (in_fire) state_d = in_last ? S_DRAIN : S_ACC;
            S_ACC:   if (in_fire && in_last) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  if (out_fire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (out_fire || acc_clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
            cnt_d = '0;
        end
        if (acc_clr) begin
            state_d = S_IDLE;
            pv_d    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rdy_en_q <= 1'b0;
            prod_q   <= '0;
            pv_q     <= 1'b0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            prod_q   <= prod_d;
            pv_q     <= pv_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: doc/signed_mac_acc.md
SIGNED_MAC_ACC -- requirements
Module: signed_mac_acc

Interface
REQ-001 Parameter DW, default 22: signed operand width in bits.
REQ-002 Parameter ACC_W, default 48: signed accumulator/result width; the design SHALL require ACC_W >= 2*DW, elaboration error otherwise.
REQ-003 Parameter CNT_W, default 16: beat-counter width.
REQ-004 Parameter SAT_EN, default 1: 1 = saturate on overflow, 0 = two's-complement wrap.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  input  1  input beat valid.
REQ-008 in_ready  output  1  block accepts beat; handshake = in_valid & in_ready at rising edge.
REQ-009 in_a  input  signed [DW-1:0]  multiplicand.
REQ-010 in_b  input  signed [DW-1:0]  multiplier.
REQ-011 in_last  input  1  marks final beat of a frame; sampled with the handshake.
REQ-012 acc_clr  input  1  synchronous frame abort/clear.
REQ-013 out_valid  output  1  frame result valid.
REQ-014 out_ready  input  1  consumer accepts result; handshake = out_valid & out_ready.
REQ-015 out_sum  output  signed [ACC_W-1:0]  frame sum of in_a*in_b.
REQ-016 out_ovf  output  1  at least one overflow occurred in the frame.
REQ-017 out_cnt  output  [CNT_W-1:0]  beats in frame, saturating at all-ones.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states: IDLE, ACC, DRAIN, DONE; IDLE -> ACC on first accepted beat without in_last; IDLE/ACC -> DRAIN on accepted beat with in_last; DRAIN -> DONE after one edge; DONE -> IDLE on out handshake.
REQ-020 in_ready SHALL be 1 in IDLE and ACC, 0 in DRAIN and DONE; no beat of the next frame is accepted until the result handshake completes.
REQ-021 Stage 1: on handshake edge k, the full-precision product in_a*in_b (2*DW bits, signed) SHALL be registered with a valid bit.
REQ-022 Stage 2: on edge k+1, the product, sign-extended to ACC_W+1 bits, SHALL be added to the accumulator.
REQ-023 If the ACC_W+1-bit sum exceeds the signed ACC_W range: SAT_EN=1 clamps to max (2^(ACC_W-1)-1) or min (-2^(ACC_W-1)); SAT_EN=0 keeps the low ACC_W bits; both modes set the frame-sticky ovf flag.
REQ-024 After saturation, later beats SHALL accumulate from the clamped value.
REQ-025 Beat counter SHALL increment on each stage-2 accumulate, holding at 2^CNT_W-1.
REQ-026 For an in_last beat accepted at edge k, out_valid SHALL be 1 from edge k+1 (DONE), with out_sum, out_ovf, out_cnt final.
REQ-027 out_sum/out_ovf/out_cnt SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 On out handshake: out_valid->0, accumulator, ovf, counter cleared to 0 on the same edge.
REQ-029 In IDLE/ACC, out_valid=0 and out_sum/out_ovf/out_cnt SHALL read 0.
REQ-030 acc_clr=1 at an edge SHALL, in any state, clear accumulator, pipeline valid, ovf, counter and out_valid, and enter IDLE; a beat presented with acc_clr=1 is not accepted (in_ready forced 0 that cycle).
REQ-031 acc_clr in DONE SHALL discard the pending result with no out handshake.
REQ-032 A single-beat frame (in_last on first beat) SHALL give out_valid at edge k+1 with out_cnt=1.

Reset
REQ-033 rst_n=0 SHALL asynchronously force state IDLE, all pipeline valids 0, accumulator 0, out_valid=0, out_sum=0, out_ovf=0, out_cnt=0, busy=0, in_ready=0 while rst_n=0.
REQ-034 in_ready SHALL rise on the first rising edge after rst_n deasserts; reset mid-frame discards the frame.

Verification (DW=8, CNT_W=8, SAT_EN=1 unless stated)
REQ-035 ACC_W=20; beats (3,4),(-5,6),(127,127,last) -> out_valid at edge after last, out_sum=16111, ovf=0, cnt=3.
REQ-036 ACC_W=16; three beats (-128,-128), last on third -> out_sum=32767, ovf=1, cnt=3; same with SAT_EN=0 -> out_sum=-16384, ovf=1.
REQ-037 ACC_W=20; single beat (-128,127,last), out_ready=0 for 5 cycles -> out_sum=-16256 stable, in_ready=0, busy=1; out_ready=1 -> out_valid=0, next frame accepted from sum 0.
REQ-038 ACC_W=20; two beats (10,10), then acc_clr=1 -> no out_valid; next frame (2,3,last) -> out_sum=6, cnt=1.
REQ-039 ACC_W=20; rst_n pulsed low asynchronously mid-frame and in DONE -> all outputs 0 immediately, next frame sums from 0.
